// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Serialises host bitstream words onto a configuration flip-flop
//            chain and optionally recirculates it once for a CRC check.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 105,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clock,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int                 c_REM_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]   c_LEN       = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]   c_LEN_M1    = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]   c_NWORDS    = CNT_W'((CHAIN_LEN + WORD_W - 1) / WORD_W);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic [c_REM_W-1:0] c_REM_ONE   = c_REM_W'(1);
    localparam logic [c_REM_W-1:0] c_WORD_BITS = c_REM_W'(WORD_W);
    localparam logic [15:0]        c_CRC_INIT  = 16'hFFFF;
    localparam logic [15:0]        c_CRC_POLY  = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_shreg;
    logic [c_REM_W-1:0]  r_rem;
    logic [CNT_W-1:0]    r_words;
    logic [CNT_W-1:0]    r_bit_count;
    logic [15:0]         r_tx_crc;
    logic [15:0]         r_rx_crc;
    logic                r_verify;
    logic                r_error;
    logic                r_head;
    logic                r_cfg_en;
    logic                w_emit;
    logic                w_accept;
    logic [15:0]         w_rx_nxt;

    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? c_CRC_POLY : 16'h0000);
    endfunction

    assign w_rx_nxt = crc_upd(r_rx_crc, ccff_tail);

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        word_ready  = 1'b0;
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                word_ready = (r_rem <= c_REM_ONE) && (r_words < c_NWORDS);
                w_accept   = word_valid && word_ready;
                w_emit     = (r_rem != '0) && (r_bit_count < c_LEN);
                // bit_count reaching CHAIN_LEN marks the final shift cycle
                if (r_bit_count == c_LEN) w_state_nxt = r_verify ? S_VERIFY : S_DONE;
            end
            S_VERIFY: begin
                if (r_bit_count == c_LEN_M1) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_shreg     <= '0;
            r_rem       <= '0;
            r_words     <= '0;
            r_bit_count <= '0;
            r_tx_crc    <= c_CRC_INIT;
            r_rx_crc    <= c_CRC_INIT;
            r_verify    <= 1'b0;
            r_error     <= 1'b0;
            r_head      <= 1'b0;
            r_cfg_en    <= 1'b0;
        end else if (abort) begin
            r_rem       <= '0;
            r_words     <= '0;
            r_bit_count <= '0;
            r_verify    <= 1'b0;
            r_error     <= 1'b0;
            r_head      <= 1'b0;
            r_cfg_en    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_rem       <= '0;
                        r_words     <= '0;
                        r_bit_count <= '0;
                        r_tx_crc    <= c_CRC_INIT;
                        r_rx_crc    <= c_CRC_INIT;
                        r_verify    <= verify_en;
                        r_error     <= 1'b0;
                        r_cfg_en    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_cfg_en <= w_emit;
                    if (w_emit) begin
                        r_head      <= r_shreg[0];
                        r_tx_crc    <= crc_upd(r_tx_crc, r_shreg[0]);
                        r_shreg     <= r_shreg >> 1;
                        r_rem       <= r_rem - c_REM_ONE;
                        r_bit_count <= r_bit_count + c_CNT_ONE;
                    end
                    // a new word overwrites the register as its last bit leaves
                    if (w_accept) begin
                        r_shreg <= word_data;
                        r_rem   <= c_WORD_BITS;
                        r_words <= r_words + c_CNT_ONE;
                    end
                    if (r_bit_count == c_LEN) begin
                        if (r_verify) r_bit_count <= '0;
                        else          r_error     <= 1'b0;
                    end
                end
                S_VERIFY: begin
                    r_rx_crc    <= w_rx_nxt;
                    r_head      <= ccff_tail;
                    r_bit_count <= r_bit_count + c_CNT_ONE;
                    if (r_bit_count == c_LEN_M1) r_error <= (w_rx_nxt != r_tx_crc);
                end
                default: ;
            endcase
        end
    end

    assign config_enable = (r_state == S_VERIFY) || ((r_state == S_LOAD) && r_cfg_en);
    assign ccff_head     = (r_state == S_VERIFY) ? ccff_tail : r_head;
    assign busy          = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign done          = (r_state == S_DONE);
    assign error         = r_error;
    assign bit_count     = r_bit_count;

endmodule
`default_nettype wire

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain driver for the programmable fabric. It takes bitstream words from a host over a valid/ready handshake and serialises them onto the head of a daisy-chained configuration flip-flop chain, one bit per `prog_clock` cycle, using `config_enable` as the shift qualifier. After loading, it can recirculate the chain once, from `ccff_tail` back to `ccff_head`, and compare a CRC of the returned bits with a CRC of the sent bits. It sits between the bitstream source and the tile-level chain head; the chain output returns on `ccff_tail`.

## Interface
- `CHAIN_LEN`, default 105: total configuration bits in the attached chain (≥1).
- `WORD_W`, default 8: host word width (≥1).
- `CNT_W`, default 16: counter width; must satisfy 2^CNT_W > CHAIN_LEN.

- `prog_clock` — in, 1: programming clock; all state is on its rising edge.
- `prog_reset_n` — in, 1: asynchronous, active-low reset.
- `start` — in, 1: begin a programming run; sampled only in IDLE or DONE.
- `verify_en` — in, 1: run the recirculation check after load; sampled together with `start`.
- `abort` — in, 1: return to IDLE from any state.
- `word_valid` — in, 1: host word available.
- `word_data` — in, WORD_W: bitstream word; shifted out LSB first.
- `word_ready` — out, 1: loader accepts `word_data` this cycle.
- `ccff_head` — out, 1: serial data to the chain head.
- `config_enable` — out, 1: chain shift qualifier; the chain shifts on every edge where it is high.
- `ccff_tail` — in, 1: serial data from the chain tail.
- `busy` — out, 1: state is LOAD or VERIFY.
- `done` — out, 1: state is DONE.
- `error` — out, 1: CRC mismatch; meaningful only while `done`=1.
- `bit_count` — out, CNT_W: bits shifted in the current phase.

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → VERIFY when CHAIN_LEN bits have been shifted and `verify_en` was latched high; otherwise LOAD → DONE.
  - VERIFY → DONE after CHAIN_LEN shifts.
  - DONE → LOAD on `start`.
  - `abort` → IDLE from any state, with priority over everything else.
- LOAD:
  - The loader holds a WORD_W shift register and a count of bits remaining in it.
  - `word_ready` = (state==LOAD) && (remaining ≤ 1) && (words accepted < ceil(CHAIN_LEN/WORD_W)). It is combinational from registered state.
  - A word is accepted on a `word_valid` && `word_ready` edge.
  - For each bit, `ccff_head` = shreg[0] and `config_enable` = 1, and tx_crc is updated with that bit.
  - With no bit available (a bubble), `config_enable` = 0 and `ccff_head` holds its value.
  - In the last word, bits above the chain length are discarded and never driven.
- VERIFY:
  - `ccff_head` = `ccff_tail` and `config_enable` = 1 for exactly CHAIN_LEN cycles, with no bubbles. This restores the chain contents.
  - rx_crc is updated with `ccff_tail` each cycle.
- CRC:
  - CRC-16-CCITT, bit-serial, init 0xFFFF.
  - Update rule: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - Both CRCs are re-initialised on `start`.
- `error`:
  - Registered on entry to DONE as (rx_crc != tx_crc) when verify ran.
  - Forced to 0 when verify was skipped.
- `bit_count` resets to 0 on `start` and on LOAD→VERIFY, and increments on each shift.
- `start` in LOAD or VERIFY is ignored. `word_valid` outside LOAD is ignored.

## Timing
- Reset values: state IDLE; `word_ready`=0, `ccff_head`=0, `config_enable`=0, `busy`=0, `done`=0, `error`=0, `bit_count`=0. Reset mid-run abandons the run; the chain holds partial data.
- `start` sampled at edge E0 → LOAD from E0, and `word_ready`=1 after E0.
- Word accepted at edge Ea → bit0 is driven with `config_enable`=1 during cycle Ea+1, and the chain captures it at edge Ea+2.
- With back-to-back words, `word_ready` rises during the last bit of the current word, so the shift stream has no gap.
- Load takes CHAIN_LEN + (bubbles) shift cycles. The last LOAD shift cycle is followed directly by the first VERIFY cycle with no idle cycle.
- VERIFY takes exactly CHAIN_LEN cycles. `done`=1 starting the cycle after the last VERIFY shift (or after the last LOAD shift when verify is skipped).
- `abort` at edge → IDLE, with `config_enable`=0 and `word_ready`=0 from the next cycle.

## Test plan
- Basic load without verify:
  - Stimulus: reset; `start` with `verify_en`=0; 14 back-to-back words 0x01..0x0E.
  - Required: exactly 105 `config_enable` cycles; `ccff_head` sequence is LSB-first; word 14 contributes only bit0 (=0); `done`=1; `error`=0; `bit_count`=105.
- Host bubbles:
  - Stimulus: `word_valid` deasserted for 3 cycles between words 5 and 6.
  - Required: `config_enable`=0 for 3 cycles; total shifts still 105; identical bit sequence.
- Verify pass:
  - Stimulus: chain model of 105 flip-flops; `verify_en`=1; words 0xA5 repeated.
  - Required: 210 shifts total; `error`=0; chain contents equal to the loaded pattern after DONE.
- Verify fail:
  - Stimulus: chain model with bit 40 stuck at 1; pattern all-zero words.
  - Required: `error`=1 in DONE.
- Abort and reset mid-run:
  - Stimulus: `abort` after 50 shifts; then assert `prog_reset_n`=0 mid-VERIFY in a second run.
  - Required: IDLE, all outputs at reset values, `config_enable`=0 the next cycle.
- Edge parameters:
  - Stimulus: CHAIN_LEN=8 with WORD_W=8; separately CHAIN_LEN=1.
  - Required: exactly 1 word accepted; shifts = CHAIN_LEN; `start` pulsed during LOAD is ignored.
